// File: rtl/xpb_lut_arbiter.sv
// Round-robin arbiter sharing one registered xpb lookup table among several requesters.
// Responses return tagged through a credit-protected output FIFO, in accept order.
module xpb_lut_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 5,
    parameter int DATA_W    = 1024,
    parameter int TAG_W     = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         lut_idx,
    input  logic [DATA_W-1:0]        lut_data,
    output logic                     rsp_valid,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [DATA_W-1:0]        rsp_data,
    input  logic                     rsp_ready
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [TAG_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  outstanding;
    logic [TAG_W-1:0]  grant_id;
    logic              accept;
    logic              credit_ok;
    logic              rsp_fire;
    logic [IDX_W-1:0]  sel_idx;
    logic              s0_valid;
    logic              s1_valid;
    logic [TAG_W-1:0]  s0_tag;
    logic [TAG_W-1:0]  s1_tag;
    logic [TAG_W-1:0]  fifo_tag  [OUT_DEPTH];
    logic [DATA_W-1:0] fifo_data [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [TAG_W-1:0]  last_tag;
    logic [DATA_W-1:0] last_data;

    // Requester id base+k, wrapping at NUM_REQ rather than 2^TAG_W.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [TAG_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return TAG_W'(sum);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign credit_ok = (outstanding < CNT_W'(OUT_DEPTH));
    assign rsp_valid = (fifo_count != {CNT_W{1'b0}});
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign sel_idx   = req_idx[grant_id*IDX_W +: IDX_W];
    // Last popped entry is kept so the outputs hold while the FIFO is empty.
    assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr]  : last_tag;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : last_data;

    // Round-robin search from rr_ptr; only one grant, none without a credit.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        grant_id  = {TAG_W{1'b0}};
        accept    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!accept && credit_ok && req_valid[rr_pick(rr_ptr, k)]) begin
                accept                       = 1'b1;
                grant_id                     = rr_pick(rr_ptr, k);
                req_ready[rr_pick(rr_ptr, k)] = 1'b1;
            end else begin
                accept = accept;
            end
        end
    end

    // Credit counter, round-robin pointer and the valid/tag pipeline alongside the table.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= {TAG_W{1'b0}};
            outstanding <= {CNT_W{1'b0}};
            lut_idx     <= {IDX_W{1'b0}};
            s0_valid    <= 1'b0;
            s0_tag      <= {TAG_W{1'b0}};
            s1_valid    <= 1'b0;
            s1_tag      <= {TAG_W{1'b0}};
        end else begin
            if (accept) begin
                rr_ptr  <= rr_pick(grant_id, 1);
                lut_idx <= sel_idx;
                s0_tag  <= grant_id;
            end
            case ({accept, rsp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            s0_valid <= accept;
            s1_valid <= s0_valid;
            s1_tag   <= s0_tag;
        end
    end

    // FIFO pointers, occupancy and the held copy of the last response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= {PTR_W{1'b0}};
            rd_ptr     <= {PTR_W{1'b0}};
            fifo_count <= {CNT_W{1'b0}};
            last_tag   <= {TAG_W{1'b0}};
            last_data  <= {DATA_W{1'b0}};
        end else begin
            if (s1_valid) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rsp_fire) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                last_tag  <= fifo_tag[rd_ptr];
                last_data <= fifo_data[rd_ptr];
            end
            case ({s1_valid, rsp_fire})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; the credit counter guarantees a free slot on every push.
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            fifo_tag[wr_ptr]  <= s1_tag;
            fifo_data[wr_ptr] <= lut_data;
        end
    end

endmodule
